// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the multicycle MIPS-subset control path:
//   - opcode / funct / REGIMM sub-op encodings taken from the instruction word
//   - 4-bit ALU control codes driven onto the shared ALU
//   - control FSM state encoding and small decode helpers
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // REGIMM sub-op (IR[20:16]) selecting bgez
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_BNE  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_BGEZ = 4'b1110;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    // Control FSM states
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    // True for the R-type functions the datapath implements
    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // R-type funct to ALU operation; unsupported codes never reach execute
    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_AND;
        endcase
    endfunction

    // Dispatch target out of DECODE; all unsupported encodings trap here
    function automatic state_t decode_target(input logic [5:0] op,
                                             input logic [5:0] f,
                                             input logic [4:0] r);
        case (op)
            OP_LW, OP_SW:    return S_MEM_ADDR;
            OP_RTYPE:        return funct_supported(f) ? S_R_EXEC : S_ILLEGAL;
            OP_ADDI, OP_LUI: return S_I_EXEC;
            OP_BEQ, OP_BNE:  return S_BRANCH;
            OP_REGIMM:       return (r == RT_BGEZ) ? S_BRANCH : S_ILLEGAL;
            OP_J:            return S_JUMP;
            default:         return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational ALU control generator for the multicycle control FSM.
//   i_state    : current control state
//   i_opcode   : IR[31:26]
//   i_funct    : IR[5:0]
//   i_rt       : IR[20:16]
//   o_alu_ctrl : 4-bit ALU operation code
// ---------------------------------------------------------------------------
module alu_op_decode
    import cpu_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic [4:0]  i_rt,
    output logic [3:0]  o_alu_ctrl
);

    // States that do not use the ALU drive 0000 so idle outputs read as zero
    always_comb begin
        o_alu_ctrl = ALU_AND;
        case (i_state)
            S_FETCH, S_DECODE, S_MEM_ADDR: o_alu_ctrl = ALU_ADD;
            S_R_EXEC:                      o_alu_ctrl = funct_to_alu(i_funct);
            S_I_EXEC:                      o_alu_ctrl = (i_opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
            S_BRANCH: begin
                // beq compares via subtract; bne/bgez have dedicated flag modes
                if (i_opcode == OP_BNE)
                    o_alu_ctrl = ALU_BNE;
                else if (i_opcode == OP_REGIMM && i_rt == RT_BGEZ)
                    o_alu_ctrl = ALU_BGEZ;
                else
                    o_alu_ctrl = ALU_SUB;
            end
            default: o_alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS-subset CPU.
//   clk, rst_n              : clock (rising edge), async active-low reset
//   opcode, funct, rt       : fields of the latched instruction register
//   alu_zero                : ALU condition flag used by branches
//   mem_ready               : single-ported memory completion handshake
//   mem_read, mem_write, iord, ir_write         : memory / IR control
//   reg_write, reg_dst, mem_to_reg              : register file control
//   alu_src_a, alu_src_b, alu_ctrl              : shared ALU control
//   pc_source, pc_en                            : PC update control
//   instr_done                                  : last-cycle pulse
//   illegal                                     : sticky trap indicator
// ---------------------------------------------------------------------------
module multicycle_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rt,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  pc_source,
    output logic        pc_en,
    output logic        instr_done,
    output logic        illegal
);

    state_t     r_state;
    logic [3:0] w_alu_ctrl;

    alu_op_decode u_alu_op_decode (
        .i_state    (r_state),
        .i_opcode   (opcode),
        .i_funct    (funct),
        .i_rt       (rt),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // State sequencing; memory states hold until the memory signals ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      r_state <= S_FETCH;
                S_FETCH:     if (mem_ready) r_state <= S_DECODE;
                S_DECODE:    r_state <= decode_target(opcode, funct, rt);
                S_MEM_ADDR:  r_state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
                S_R_EXEC:    r_state <= S_R_WB;
                S_I_EXEC:    r_state <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                             r_state <= S_FETCH;
                S_ILLEGAL:   r_state <= S_ILLEGAL;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from the state register so an async reset clears them
    // immediately; only the memory-gated strobes and branch pc_en look at inputs
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_en      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_source  = 2'b01;
                pc_en      = alu_zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign alu_ctrl = w_alu_ctrl;

endmodule
